// File: rtl/introduction_1.sv
// Dual AND-OR cell: combinational sum-of-products plus registered copies and change pulses.
// Comb outputs have zero latency; registered outputs lag by one clk; no flow control.
module introduction_1 (
   input  logic clk,
   input  logic rst,
   input  logic p1a,
   input  logic p1b,
   input  logic p1c,
   input  logic p1d,
   input  logic p1e,
   input  logic p1f,
   input  logic p2a,
   input  logic p2b,
   input  logic p2c,
   input  logic p2d,
   output logic p1y,
   output logic p2y,
   output logic p1y_q,
   output logic p2y_q,
   output logic p1y_chg,
   output logic p2y_chg
);

   assign p1y = (p1a & p1b & p1c) | (p1d & p1e & p1f);
   assign p2y = (p2a & p2b) | (p2c & p2d);

   // The change pulse compares the new sample against the value currently held,
   // so the first edge after reset compares against the reset value 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         p1y_q   <= 1'b0;
         p2y_q   <= 1'b0;
         p1y_chg <= 1'b0;
         p2y_chg <= 1'b0;
      end else begin
         p1y_q   <= p1y;
         p2y_q   <= p2y;
         p1y_chg <= p1y ^ p1y_q;
         p2y_chg <= p2y ^ p2y_q;
      end
   end

endmodule

// File: tb/tb_introduction_1.sv
// Bench for introduction_1: history-based model checked every cycle plus literal directed checks.
module tb_introduction_1;

   logic clk = 1'b0;
   logic clk_en = 1'b0;
   logic chk_en = 1'b0;
   logic rst;
   logic p1a, p1b, p1c, p1d, p1e, p1f, p2a, p2b, p2c, p2d;
   logic p1y, p2y, p1y_q, p2y_q, p1y_chg, p2y_chg;

   int n_cmp = 0;
   int n_bad = 0;

   introduction_1 dut (
      .clk(clk), .rst(rst),
      .p1a(p1a), .p1b(p1b), .p1c(p1c), .p1d(p1d), .p1e(p1e), .p1f(p1f),
      .p2a(p2a), .p2b(p2b), .p2c(p2c), .p2d(p2d),
      .p1y(p1y), .p2y(p2y), .p1y_q(p1y_q), .p2y_q(p2y_q),
      .p1y_chg(p1y_chg), .p2y_chg(p2y_chg)
   );

   initial begin
      forever begin
         #5;
         if (clk_en) clk = ~clk;
      end
   end

   // Cell rules stated as "all inputs of a term are high".
   function automatic logic m1(input logic [5:0] v);
      return ($countones(v[5:3]) == 3) || ($countones(v[2:0]) == 3);
   endfunction

   function automatic logic m2(input logic [3:0] v);
      return ($countones(v[3:2]) == 2) || ($countones(v[1:0]) == 2);
   endfunction

   task automatic chk(input string name, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic set_in(input logic [9:0] v);
      {p1a, p1b, p1c, p1d, p1e, p1f, p2a, p2b, p2c, p2d} = v;
   endtask

   // Model: the list of cell values sampled at each edge since reset, seeded with
   // two reset zeros. Registered output = newest sample; pulse = newest differs from previous.
   logic h1[$];
   logic h2[$];

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         h1 = '{1'b0, 1'b0};
         h2 = '{1'b0, 1'b0};
      end else begin
         h1.push_back(m1({p1a, p1b, p1c, p1d, p1e, p1f}));
         h2.push_back(m2({p2a, p2b, p2c, p2d}));
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("cyc_p1y", p1y, m1({p1a, p1b, p1c, p1d, p1e, p1f}));
         chk("cyc_p2y", p2y, m2({p2a, p2b, p2c, p2d}));
         chk("cyc_p1y_q", p1y_q, h1[$]);
         chk("cyc_p2y_q", p2y_q, h2[$]);
         chk("cyc_p1y_chg", p1y_chg, h1[$] != h1[$-1]);
         chk("cyc_p2y_chg", p2y_chg, h2[$] != h2[$-1]);
      end
   end

   task automatic edge_settle();
      @(posedge clk);
      #1;
   endtask

   logic [9:0] vecs [0:7];

   initial begin
      int ones;
      vecs[0] = 10'b111000_0000;
      vecs[1] = 10'b000111_1100;
      vecs[2] = 10'b110110_0011;
      vecs[3] = 10'b110110_0011;
      vecs[4] = 10'b111111_1111;
      vecs[5] = 10'b011011_1010;
      vecs[6] = 10'b001111_0101;
      vecs[7] = 10'b000000_0000;

      // No clock, reset undriven: combinational path alone.
      set_in(10'b111101_0101);
      #10;
      chk("t1_p1y", p1y, 1'b1);
      chk("t1_p2y", p2y, 1'b0);

      ones = 0;
      for (int i = 0; i < 64; i++) begin
         {p1a, p1b, p1c, p1d, p1e, p1f} = 6'(i);
         #1;
         chk("t2_p1y", p1y, m1(6'(i)));
         if (p1y === 1'b1) ones++;
      end
      n_cmp++;
      if (ones != 15) begin
         n_bad++;
         $display("FAIL t2_p1_count: got %0d ones, expected 15", ones);
      end
      ones = 0;
      for (int i = 0; i < 16; i++) begin
         {p2a, p2b, p2c, p2d} = 4'(i);
         #1;
         chk("t2_p2y", p2y, m2(4'(i)));
         if (p2y === 1'b1) ones++;
      end
      n_cmp++;
      if (ones != 7) begin
         n_bad++;
         $display("FAIL t2_p2_count: got %0d ones, expected 7", ones);
      end

      // Asynchronous reset with no clock running.
      set_in(10'b111111_1111);
      #1;
      rst = 1'b1;
      #1;
      chk("t3_p1y_q", p1y_q, 1'b0);
      chk("t3_p2y_q", p2y_q, 1'b0);
      chk("t3_p1y_chg", p1y_chg, 1'b0);
      chk("t3_p2y_chg", p2y_chg, 1'b0);
      chk("t3_p1y", p1y, 1'b1);
      chk("t3_p2y", p2y, 1'b1);

      clk_en = 1'b1;
      edge_settle();
      edge_settle();
      chk("t3_rst_edge_q", p1y_q, 1'b0);
      @(negedge clk);
      chk_en = 1'b1;
      #1;
      rst = 1'b0;

      edge_settle();
      chk("t4_p1y_q", p1y_q, 1'b1);
      chk("t4_p2y_q", p2y_q, 1'b1);
      chk("t4_p1y_chg", p1y_chg, 1'b1);
      chk("t4_p2y_chg", p2y_chg, 1'b1);
      edge_settle();
      chk("t4_p1y_chg2", p1y_chg, 1'b0);
      chk("t4_p2y_chg2", p2y_chg, 1'b0);

      p2a = 1'b0;
      #1;
      chk("t5_p2y_hold", p2y, 1'b1);
      p2d = 1'b0;
      #1;
      chk("t5_p2y_now", p2y, 1'b0);
      edge_settle();
      chk("t5_p2y_q", p2y_q, 1'b0);
      chk("t5_p2y_chg", p2y_chg, 1'b1);
      chk("t5_p1y_chg", p1y_chg, 1'b0);
      edge_settle();
      chk("t5_p2y_chg2", p2y_chg, 1'b0);

      // Directed vectors, one per cycle, with a between-edge glitch on the odd ones.
      for (int i = 0; i < 8; i++) begin
         set_in(vecs[i]);
         if (i % 2 == 1) begin
            #2;
            {p1d, p1e, p1f} = 3'b111;
            #1;
            {p1d, p1e, p1f} = vecs[i][6:4];
         end
         edge_settle();
      end
      chk("glitch_p1y_q", p1y_q, 1'b0);

      // Mid-stream reset while p1y_q is high.
      set_in(10'b111000_1100);
      edge_settle();
      chk("t6_pre_p1y_q", p1y_q, 1'b1);
      #2;
      rst = 1'b1;
      #1;
      chk("t6_p1y_q", p1y_q, 1'b0);
      chk("t6_p1y_chg", p1y_chg, 1'b0);
      chk("t6_p1y", p1y, 1'b1);
      edge_settle();
      edge_settle();
      chk("t6_hold_p1y_q", p1y_q, 1'b0);
      chk("t6_hold_p2y_q", p2y_q, 1'b0);
      chk("t6_hold_p1y_chg", p1y_chg, 1'b0);
      chk("t6_hold_p2y_chg", p2y_chg, 1'b0);
      rst = 1'b0;
      for (int i = 7; i >= 0; i--) begin
         set_in(vecs[i]);
         edge_settle();
      end
      @(negedge clk);
      chk_en = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
